// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with optional write-back bypass and per-register busy scoreboard.
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             hazard,
  output logic [AW:0]      busy_count
);
  logic [WIDTH-1:0] regs_q [NREGS-1:1];
  logic [WIDTH-1:0] regs_d [NREGS-1:1];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_count_q, busy_count_d;
  logic             wb_hit, byp1, byp2;
  // gating with rst keeps the bypass path from leaking wb_data while in reset
  assign wb_hit = rst && wb_valid && wb_rd != '0;
  assign byp1 = BYPASS != 0 && wb_hit && rs1_addr == wb_rd;
  assign byp2 = BYPASS != 0 && wb_hit && rs2_addr == wb_rd;
  assign busy_count = busy_count_q;
  always_comb begin
    rs1_data = rs1_addr == '0 ? '0 : byp1 ? wb_data : regs_q[rs1_addr];
    rs2_data = rs2_addr == '0 ? '0 : byp2 ? wb_data : regs_q[rs2_addr];
    hazard = (rs1_addr != '0 && busy_q[rs1_addr] && !byp1) ||
             (rs2_addr != '0 && busy_q[rs2_addr] && !byp2);
  end
  // clear before set so a same-cycle issue to the write-back target stays busy
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_hit) begin
      regs_d[wb_rd] = wb_data;
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    busy_count_d = '0;
    for (int i = 1; i < NREGS; i++) busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random checks of regfile_scoreboard against a behavioural model.
module tb_regfile_scoreboard;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    rs1_addr, rs2_addr, issue_rd, wb_rd;
  logic [WIDTH-1:0] rs1_data, rs2_data, wb_data;
  logic             issue_valid, wb_valid, hazard;
  logic [AW:0]      busy_count;
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] m_regs [NREGS];
  bit               m_busy [NREGS];
  regfile_scoreboard #(.WIDTH(WIDTH), .NREGS(NREGS), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .hazard(hazard), .busy_count(busy_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: architectural state as plain arrays, updated on each edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 0;
      end
    end else begin
      if (wb_valid && wb_rd != 0) begin
        m_regs[wb_rd] = wb_data;
        m_busy[wb_rd] = 0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
    end
  end
  function automatic logic [WIDTH-1:0] exp_data(input logic [AW-1:0] a);
    if (!rst || a == 0) return '0;
    if (wb_valid && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction
  function automatic bit exp_src_haz(input logic [AW-1:0] a);
    return rst && a != 0 && m_busy[a] && !(wb_valid && wb_rd == a);
  endfunction
  function automatic int exp_count();
    int n = 0;
    for (int i = 1; i < NREGS; i++) n += m_busy[i];
    return n;
  endfunction
  always @(negedge clk) begin
    check("rs1_data", rs1_data, exp_data(rs1_addr));
    check("rs2_data", rs2_data, exp_data(rs2_addr));
    check("hazard", hazard, exp_src_haz(rs1_addr) || exp_src_haz(rs2_addr));
    check("busy_count", busy_count, exp_count());
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    issue_valid = 0; wb_valid = 0;
  endtask
  initial begin
    rst = 0; rs1_addr = 0; rs2_addr = 0; issue_rd = 0; wb_rd = 0; wb_data = 0;
    issue_valid = 0; wb_valid = 0;
    repeat (2) step();
    rst = 1;
    @(negedge clk);
    check("reset_count", busy_count, 0);
    check("reset_rs1", rs1_data, 0);
    step();
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    step();
    idle(); rs1_addr = 5; rs2_addr = 0;
    @(negedge clk);
    check("x5_read", rs1_data, 32'hDEADBEEF);
    check("x0_read", rs2_data, 0);
    issue_valid = 1; issue_rd = 7;
    step();
    idle(); rs2_addr = 7;
    @(negedge clk);
    check("x7_busy_hazard", hazard, 1);
    wb_valid = 1; wb_rd = 7; wb_data = 32'h1234;
    @(negedge clk);
    check("bypass_data", rs2_data, 32'h1234);
    check("bypass_no_hazard", hazard, 0);
    step();
    idle();
    @(negedge clk);
    check("x7_written", rs2_data, 32'h1234);
    check("x7_cleared", busy_count, 0);
    issue_valid = 1; issue_rd = 3; rs2_addr = 0;
    step();
    idle(); rs1_addr = 3;
    @(negedge clk);
    check("x3_hazard", hazard, 1);
    check("x3_count", busy_count, 1);
    wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
    step();
    idle();
    @(negedge clk);
    check("x3_hazard_clr", hazard, 0);
    check("x3_count_clr", busy_count, 0);
    issue_valid = 1; issue_rd = 4;
    step();
    wb_valid = 1; wb_rd = 4; wb_data = 32'h44;
    step();
    idle(); rs1_addr = 4;
    @(negedge clk);
    check("issue_wins_count", busy_count, 1);
    check("issue_wins_hazard", hazard, 1);
    wb_valid = 1;
    step();
    idle();
    issue_valid = 1; issue_rd = 0; wb_valid = 1; wb_rd = 0; wb_data = 32'hFFFF; rs1_addr = 0;
    @(negedge clk);
    check("x0_bypass", rs1_data, 0);
    check("x0_hazard", hazard, 0);
    step();
    idle();
    @(negedge clk);
    check("x0_read_after", rs1_data, 0);
    check("x0_count", busy_count, 0);
    for (int c = 0; c < 2000; c++) begin
      issue_valid = $urandom_range(0, 3) == 0;
      issue_rd = AW'($urandom);
      wb_valid = $urandom_range(0, 2) == 0;
      wb_rd = AW'($urandom);
      wb_data = $urandom;
      rs1_addr = AW'($urandom);
      rs2_addr = AW'($urandom);
      step();
    end
    idle();
    wb_valid = 1; wb_rd = 9; wb_data = 32'hA5A5A5A5;
    step();
    idle();
    for (int r = 1; r < NREGS; r++) begin
      issue_valid = 1; issue_rd = AW'(r);
      step();
    end
    idle(); rs1_addr = 9; rs2_addr = 31;
    @(negedge clk);
    check("all_busy_count", busy_count, 31);
    check("pre_reset_x9", rs1_data, 32'hA5A5A5A5);
    step();
    #2 rst = 0;
    #1;
    check("async_count", busy_count, 0);
    check("async_rs1", rs1_data, 0);
    check("async_rs2", rs2_data, 0);
    check("async_hazard", hazard, 0);
    wb_valid = 1; wb_rd = 9; wb_data = 32'h77; rs1_addr = 9;
    step();
    #1;
    check("reset_ignores_wb", rs1_data, 0);
    idle();
    rst = 1;
    for (int c = 0; c < 200; c++) begin
      issue_valid = $urandom_range(0, 1) == 0;
      issue_rd = AW'($urandom);
      wb_valid = $urandom_range(0, 1) == 0;
      wb_rd = AW'($urandom);
      wb_data = $urandom;
      rs1_addr = AW'($urandom);
      rs2_addr = AW'($urandom);
      step();
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each register.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers including x0; legal values are powers of 2 from 2 to 32.
REQ-003 SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding when 1.
REQ-004 SHALL derive local AW = log2(NREGS), the address width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have ports rs1_addr and rs2_addr, input, AW each, read addresses.
REQ-008 SHALL have ports rs1_data and rs2_data, output, WIDTH each, read data.
REQ-009 SHALL have port issue_valid, input, 1, an instruction that will write issue_rd is issuing this cycle.
REQ-010 SHALL have port issue_rd, input, AW, destination register of the issuing instruction.
REQ-011 SHALL have port wb_valid, input, 1, write-back strobe.
REQ-012 SHALL have port wb_rd, input, AW, write-back destination.
REQ-013 SHALL have port wb_data, input, WIDTH, write-back data.
REQ-014 SHALL have port hazard, output, 1, a source register has an outstanding write.
REQ-015 SHALL have port busy_count, output, AW+1, number of registers currently marked busy.

Function
REQ-016 SHALL store NREGS-1 registers; x0 is not stored and always reads 0.
REQ-017 SHALL write wb_data to register wb_rd on a rising clk edge when wb_valid=1 and wb_rd!=0; writes to x0 are discarded.
REQ-018 SHALL return register contents combinationally on rs1_data/rs2_data (zero read latency).
REQ-019 SHALL, when BYPASS=1, wb_valid=1, wb_rd!=0 and rsN_addr==wb_rd, return wb_data on rsN_data in the same cycle; when BYPASS=0 the pre-write value is returned.
REQ-020 SHALL keep one busy bit per register; x0's busy bit is constant 0.
REQ-021 SHALL set busy[issue_rd] on a clock edge when issue_valid=1 and issue_rd!=0.
REQ-022 SHALL clear busy[wb_rd] on a clock edge when wb_valid=1 and wb_rd!=0.
REQ-023 SHALL, when issue and write-back target the same register in one cycle, leave that busy bit set (issue wins).
REQ-024 SHALL drive hazard=1 when busy[rs1_addr] or busy[rs2_addr] is 1, except that a source matching a same-cycle valid write-back with BYPASS=1 is not hazardous; address 0 is never hazardous.
REQ-025 SHALL not include issue_valid/issue_rd of the current cycle in hazard (only registered busy state).
REQ-026 SHALL update busy_count registered, equal to the population count of busy bits after each edge; range 0 to NREGS-1, no wrap.
REQ-027 SHALL treat write-back to a non-busy register as a normal write with no busy-count change.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear all registers to 0, all busy bits to 0, and busy_count to 0.
REQ-029 SHALL hold rs1_data=rs2_data=0, hazard=0 during reset; writes and issues are ignored while rst=0.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst returns to 1; reset asserted mid-cycle discards any pending update.

Verification
REQ-031 SHALL cover: reset, then wb x5=0xDEADBEEF; next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF; rs2_addr=0 -> 0.
REQ-032 SHALL cover: BYPASS=1, wb_valid=1 wb_rd=7 wb_data=0x1234 with rs2_addr=7 same cycle -> rs2_data=0x1234, hazard=0 even if busy[7]=1.
REQ-033 SHALL cover: issue rd=3; next cycle rs1_addr=3 -> hazard=1, busy_count=1; wb rd=3 -> following cycle hazard=0, busy_count=0.
REQ-034 SHALL cover: same cycle issue rd=4 and wb rd=4 with busy[4]=1 -> busy[4] stays 1, busy_count unchanged.
REQ-035 SHALL cover: issue rd=0 and wb rd=0 data 0xFFFF -> x0 reads 0, busy_count stays 0, hazard=0.
REQ-036 SHALL cover: issue 31 distinct registers -> busy_count=31; assert rst=0 asynchronously mid-cycle -> busy_count=0, all reads 0 immediately.
